// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side pointer/full controller; 1 wr_clk edge from accepted write to updated pointers/status.
// Backpressure: wr_accept drops while full; writes attempted while full are dropped and set sticky overflow.
module fifo_wr_ctrl #(
  parameter int ADDR_SIZE = 4,
  parameter int AF_THRESH = 12
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst,
  input  logic                 wr_en,
  input  logic                 ovf_clr,
  input  logic [ADDR_SIZE:0]   rd_ptr_addr_sync,
  output logic                 wr_accept,
  output logic [ADDR_SIZE-1:0] wr_addr_bin,
  output logic [ADDR_SIZE:0]   wr_addr_grey,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_SIZE:0]   wr_level,
  output logic                 overflow
);

  localparam logic [ADDR_SIZE+1:0] AF_VAL = (ADDR_SIZE+2)'(AF_THRESH);

  logic [ADDR_SIZE:0] r_wbin;
  logic [ADDR_SIZE:0] r_wgrey;
  logic               r_full;
  logic               r_af;
  logic [ADDR_SIZE:0] r_level;
  logic               r_ovf;

  logic [ADDR_SIZE:0] w_wbin_next;
  logic [ADDR_SIZE:0] w_wgrey_next;
  logic [ADDR_SIZE:0] w_rbin;
  logic [ADDR_SIZE:0] w_full_ptr;
  logic [ADDR_SIZE:0] w_level_next;
  logic               w_full_next;
  logic               w_af_next;

  assign wr_accept    = wr_en & ~r_full;
  assign w_wbin_next  = r_wbin + {{ADDR_SIZE{1'b0}}, wr_accept};
  assign w_wgrey_next = (w_wbin_next >> 1) ^ w_wbin_next;

  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
  assign w_full_ptr  = {~rd_ptr_addr_sync[ADDR_SIZE:ADDR_SIZE-1], rd_ptr_addr_sync[ADDR_SIZE-2:0]};
  assign w_full_next = (w_wgrey_next == w_full_ptr);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      w_rbin[i] = ^(rd_ptr_addr_sync >> i);
    end
  end

  assign w_level_next = w_wbin_next - w_rbin;
  assign w_af_next    = ({1'b0, w_level_next} >= AF_VAL);

  always_ff @(posedge wr_clk) begin
    if (!wr_rst) begin
      r_wbin  <= '0;
      r_wgrey <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgrey <= w_wgrey_next;
      r_full  <= w_full_next;
      r_af    <= w_af_next;
      r_level <= w_level_next;
      if (wr_en && r_full) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign wr_addr_bin  = r_wbin[ADDR_SIZE-1:0];
  assign wr_addr_grey = r_wgrey;
  assign full         = r_full;
  assign almost_full  = r_af;
  assign wr_level     = r_level;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with ADDR_SIZE=4, AF_THRESH=12.
module tb_fifo_wr_ctrl;

  logic       wr_clk = 1'b0;
  logic       wr_rst;
  logic       wr_en;
  logic       ovf_clr;
  logic [4:0] rd_ptr_addr_sync;
  logic       wr_accept;
  logic [3:0] wr_addr_bin;
  logic [4:0] wr_addr_grey;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow;

  int n_chk = 0;
  int n_bad = 0;

  fifo_wr_ctrl #(.ADDR_SIZE(4), .AF_THRESH(12)) dut (
    .wr_clk           (wr_clk),
    .wr_rst           (wr_rst),
    .wr_en            (wr_en),
    .ovf_clr          (ovf_clr),
    .rd_ptr_addr_sync (rd_ptr_addr_sync),
    .wr_accept        (wr_accept),
    .wr_addr_bin      (wr_addr_bin),
    .wr_addr_grey     (wr_addr_grey),
    .full             (full),
    .almost_full      (almost_full),
    .wr_level         (wr_level),
    .overflow         (overflow)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [4:0] wb;

  initial begin
    wr_rst = 1'b0;
    wr_en = 1'b1;
    ovf_clr = 1'b0;
    rd_ptr_addr_sync = 5'd0;
    #1;
    tick();
    tick();
    chk("rst_addr_bin", 32'(wr_addr_bin), 0);
    chk("rst_grey", 32'(wr_addr_grey), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_level", 32'(wr_level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_accept", 32'(wr_accept), 1);

    // First write after release, then keep writing to 16 entries.
    wr_rst = 1'b1;
    tick();
    chk("w1_addr_bin", 32'(wr_addr_bin), 1);
    chk("w1_grey", 32'(wr_addr_grey), 32'h01);
    chk("w1_level", 32'(wr_level), 1);
    for (int n = 2; n <= 16; n++) begin
      tick();
      chk("fill_level", 32'(wr_level), 32'(n));
      chk("fill_af", 32'(almost_full), (n >= 12) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(full), (n == 16) ? 32'd1 : 32'd0);
    end
    chk("full_grey", 32'(wr_addr_grey), 32'h18);
    chk("full_addr_bin", 32'(wr_addr_bin), 0);
    chk("full_accept", 32'(wr_accept), 0);
    chk("full_ovf_pre", 32'(overflow), 0);

    // Writes while full are refused and set overflow.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ovf_grey", 32'(wr_addr_grey), 32'h18);
      chk("ovf_level", 32'(wr_level), 16);
      chk("ovf_flag", 32'(overflow), 1);
    end
    wr_en = 1'b0;
    ovf_clr = 1'b1;
    tick();
    chk("ovf_clr", 32'(overflow), 0);
    wr_en = 1'b1;
    tick();
    chk("ovf_set_wins", 32'(overflow), 1);
    ovf_clr = 1'b0;
    wr_en = 1'b0;

    // Read pointer advances: status follows one edge later.
    rd_ptr_addr_sync = 5'b00110;
    tick();
    chk("drain_full", 32'(full), 0);
    chk("drain_level12", 32'(wr_level), 12);
    chk("drain_af12", 32'(almost_full), 1);
    rd_ptr_addr_sync = 5'b00111;
    tick();
    chk("drain_level11", 32'(wr_level), 11);
    chk("drain_af11", 32'(almost_full), 0);
    chk("drain_ovf_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    chk("drain_ovf_clr", 32'(overflow), 0);
    ovf_clr = 1'b0;

    // Wrap-around with read pointer trailing by two.
    wb = 5'd16;
    wr_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rd_ptr_addr_sync = gray(wb - 5'd1);
      tick();
      wb = wb + 5'd1;
      chk("wrap_level", 32'(wr_level), 2);
      chk("wrap_full", 32'(full), 0);
      chk("wrap_ovf", 32'(overflow), 0);
      chk("wrap_grey", 32'(wr_addr_grey), 32'(gray(wb)));
      if (wb == 5'd31) chk("wrap_grey31", 32'(wr_addr_grey), 32'h10);
      if (wb == 5'd0) chk("wrap_grey0", 32'(wr_addr_grey), 32'h00);
    end
    chk("wrap_addr_bin", 32'(wr_addr_bin), 32'(wb[3:0]));

    // Seven more writes, then reset mid-burst.
    for (int k = 0; k < 7; k++) begin
      rd_ptr_addr_sync = gray(wb - 5'd1);
      tick();
      wb = wb + 5'd1;
    end
    chk("pre_rst_grey", 32'(wr_addr_grey), 32'(gray(5'd31)));
    wr_rst = 1'b0;
    tick();
    chk("mrst_level", 32'(wr_level), 0);
    chk("mrst_grey", 32'(wr_addr_grey), 0);
    chk("mrst_addr_bin", 32'(wr_addr_bin), 0);
    chk("mrst_full", 32'(full), 0);
    chk("mrst_ovf", 32'(overflow), 0);
    wr_rst = 1'b1;
    wr_en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
